// File: rtl/turn_pkg.sv
// ---------------------------------------------------------------
// turn_pkg : shared state encoding and default constants for the
//            two-player turn sequencer.  Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package turn_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_FIRE   = 3'd2,
    S_FLIGHT = 3'd3,
    S_SWITCH = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam int POS_W_DEF        = 8;
  localparam int POS_MIN_DEF      = 8;
  localparam int POS_MAX_DEF      = 247;
  localparam int P0_START_DEF     = 40;
  localparam int P1_START_DEF     = 215;
  localparam int ANG_W_DEF        = 4;
  localparam int MOVE_BUDGET_DEF  = 32;
  localparam int TURN_TIMEOUT_DEF = 600;

endpackage

`default_nettype wire

// File: rtl/turn_sequencer_sat_step.sv
// ---------------------------------------------------------------
// sat_step : loadable register stepping +/-1 with saturation at
//            MIN/MAX; flags the cycles where the value moves. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sat_step #(
  parameter int W    = 8,
  parameter int MIN  = 0,
  parameter int MAX  = 255,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] value,
  output logic         changed
);

  logic [W-1:0] value_q, value_d;
  logic         inc_ok, dec_ok;

  always_comb begin
    inc_ok  = en & up & ~down & (value_q < W'(MAX));
    dec_ok  = en & down & ~up & (value_q > W'(MIN));
    changed = ~load & (inc_ok | dec_ok);
    value_d = value_q;
    if (load)        value_d = W'(INIT);
    else if (inc_ok) value_d = value_q + W'(1);
    else if (dec_ok) value_d = value_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= W'(INIT);
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

`default_nettype wire

// File: rtl/turn_sequencer.sv
// ---------------------------------------------------------------
// turn_sequencer : two-player turn controller owning tank position
//                  and aim registers and the fire/flight handshake. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module turn_sequencer
  import turn_pkg::*;
#(
  parameter int POS_W        = POS_W_DEF,
  parameter int POS_MIN      = POS_MIN_DEF,
  parameter int POS_MAX      = POS_MAX_DEF,
  parameter int P0_START     = P0_START_DEF,
  parameter int P1_START     = P1_START_DEF,
  parameter int ANG_W        = ANG_W_DEF,
  parameter int MOVE_BUDGET  = MOVE_BUDGET_DEF,
  parameter int TURN_TIMEOUT = TURN_TIMEOUT_DEF,
  localparam int MV_W        = $clog2(MOVE_BUDGET + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_new_game,
  input  logic             tick,
  input  logic             left_x,
  input  logic             right_x,
  input  logic             left_aim,
  input  logic             right_aim,
  input  logic             shoot_in,
  input  logic             proj_done,
  input  logic             proj_hit,
  output logic             active_player,
  output logic [POS_W-1:0] p0_x,
  output logic [POS_W-1:0] p1_x,
  output logic [ANG_W-1:0] p0_ang,
  output logic [ANG_W-1:0] p1_ang,
  output logic [MV_W-1:0]  moves_left,
  output logic             fire,
  output logic [2:0]       state,
  output logic             game_over,
  output logic             winner
);

  localparam int CNT_W   = $clog2(TURN_TIMEOUT + 1);
  localparam int ANG_MAX = (1 << ANG_W) - 1;
  localparam int ANG_MID = 1 << (ANG_W - 1);

  state_t            state_q, state_d;
  logic              active_q, active_d;
  logic [MV_W-1:0]   moves_q, moves_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              shoot_prev_q, shoot_prev_d;
  logic              winner_q, winner_d;

  logic              fire_edge, act, btn_multi, timeout;
  logic [2:0]        btn_cnt;
  logic [1:0]        x_en, ang_en, x_chg, ang_chg;

  // A step is taken only on a quiet tick: no shoot edge and at most one button level.
  always_comb begin
    fire_edge = shoot_in & ~shoot_prev_q;
    btn_cnt   = 3'(left_x) + 3'(right_x) + 3'(left_aim) + 3'(right_aim);
    btn_multi = btn_cnt > 3'd1;
    act       = (state_q == S_PLAY) & tick & ~fire_edge & ~btn_multi & ~start_new_game;
    cnt_inc   = cnt_q + CNT_W'(1);
    timeout   = tick & (cnt_inc == CNT_W'(TURN_TIMEOUT));
    x_en[0]   = act & ~active_q & (moves_q != '0);
    x_en[1]   = act &  active_q & (moves_q != '0);
    ang_en[0] = act & ~active_q;
    ang_en[1] = act &  active_q;
  end

  sat_step #(.W(POS_W), .MIN(POS_MIN), .MAX(POS_MAX), .INIT(P0_START)) u_p0_x (
    .clk(clk), .reset(reset), .load(start_new_game), .en(x_en[0]),
    .up(right_x), .down(left_x), .value(p0_x), .changed(x_chg[0]));

  sat_step #(.W(POS_W), .MIN(POS_MIN), .MAX(POS_MAX), .INIT(P1_START)) u_p1_x (
    .clk(clk), .reset(reset), .load(start_new_game), .en(x_en[1]),
    .up(right_x), .down(left_x), .value(p1_x), .changed(x_chg[1]));

  sat_step #(.W(ANG_W), .MIN(0), .MAX(ANG_MAX), .INIT(ANG_MID)) u_p0_ang (
    .clk(clk), .reset(reset), .load(start_new_game), .en(ang_en[0]),
    .up(right_aim), .down(left_aim), .value(p0_ang), .changed(ang_chg[0]));

  sat_step #(.W(ANG_W), .MIN(0), .MAX(ANG_MAX), .INIT(ANG_MID)) u_p1_ang (
    .clk(clk), .reset(reset), .load(start_new_game), .en(ang_en[1]),
    .up(right_aim), .down(left_aim), .value(p1_ang), .changed(ang_chg[1]));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_new_game) begin
      state_d = S_PLAY;
    end else begin
      case (state_q)
        S_PLAY:   if (fire_edge) state_d = S_FIRE;
                  else if (timeout) state_d = S_SWITCH;
        S_FIRE:   state_d = S_FLIGHT;
        S_FLIGHT: if (proj_done) state_d = proj_hit ? S_OVER : S_SWITCH;
        S_SWITCH: state_d = S_PLAY;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    fire      = (state_q == S_FIRE);
    game_over = (state_q == S_OVER);
    state     = state_q;
  end

  always_comb begin
    active_d     = active_q;
    moves_d      = moves_q;
    cnt_d        = cnt_q;
    winner_d     = winner_q;
    shoot_prev_d = shoot_in;
    if (start_new_game) begin
      active_d     = 1'b0;
      moves_d      = MV_W'(MOVE_BUDGET);
      cnt_d        = '0;
      winner_d     = 1'b0;
      shoot_prev_d = 1'b0;
    end else if (state_q == S_SWITCH) begin
      active_d = ~active_q;
      moves_d  = MV_W'(MOVE_BUDGET);
      cnt_d    = '0;
    end else begin
      if (x_chg[0] | x_chg[1])                       moves_d = moves_q - MV_W'(1);
      if ((state_q == S_PLAY) & tick & ~fire_edge)   cnt_d   = cnt_inc;
      if ((state_q == S_FLIGHT) & proj_done & proj_hit) winner_d = active_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q     <= 1'b0;
      moves_q      <= MV_W'(MOVE_BUDGET);
      cnt_q        <= '0;
      shoot_prev_q <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      active_q     <= active_d;
      moves_q      <= moves_d;
      cnt_q        <= cnt_d;
      shoot_prev_q <= shoot_prev_d;
      winner_q     <= winner_d;
    end
  end

  assign active_player = active_q;
  assign moves_left    = moves_q;
  assign winner        = winner_q;

endmodule

`default_nettype wire

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Two-player turn controller that sits downstream of the one-hot button decoder.
- Owns each tank's x-position and aim-angle registers, and applies the decoded move/aim levels on frame ticks to the active player only.
- Sequences each turn through play, fire, projectile flight and hand-over, and declares a winner when a hit is reported.
- Drives the projectile engine through a fire pulse and waits for its done/hit handshake.

Parameters:
POS_W, 8, width of x-position registers
POS_MIN, 8, lowest legal tank x
POS_MAX, 247, highest legal tank x
P0_START, 40, player-0 x after reset/new game
P1_START, 215, player-1 x after reset/new game
ANG_W, 4, aim-angle width; angle range 0..2^ANG_W-1
MOVE_BUDGET, 32, position steps allowed per turn
TURN_TIMEOUT, 600, ticks in PLAY before the turn is forfeited

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start_new_game  in  1  level; restarts game
tick  in  1  one-cycle frame strobe
left_x  in  1  move-left level (decoded, one-hot with others)
right_x  in  1  move-right level
left_aim  in  1  aim decrement level
right_aim  in  1  aim increment level
shoot_in  in  1  shoot level
proj_done  in  1  one-cycle pulse: projectile finished
proj_hit  in  1  valid with proj_done; 1 = opponent hit
active_player  out  1  0/1, whose turn
p0_x, p1_x  out  POS_W  tank positions
p0_ang, p1_ang  out  ANG_W  aim angles
moves_left  out  clog2(MOVE_BUDGET+1)  remaining steps this turn
fire  out  1  one-cycle pulse to projectile engine
state  out  3  FSM state encoding (debug/display)
game_over  out  1  high in OVER
winner  out  1  valid while game_over

Behaviour:
- Reset is synchronous and active-high on clk. It forces:
  - state IDLE, active_player 0
  - p0_x=P0_START, p1_x=P1_START, both angles = 2^(ANG_W-1)
  - moves_left=MOVE_BUDGET, fire 0, game_over 0, winner 0
  - tick counter 0, shoot_prev 0
- Priority order: reset > start_new_game > FSM transitions.
- start_new_game in any state reloads every reset value above except state, and enters PLAY with player 0.
- States: IDLE, PLAY, FIRE, FLIGHT, SWITCH, OVER.
- IDLE: waits for start_new_game. All other inputs are ignored.
- PLAY, actions applied when tick=1 and no fire edge occurs that cycle:
  - left_x/right_x step the active x by ±1. The step saturates at POS_MIN/POS_MAX and requires moves_left>0.
  - moves_left decrements only when the position actually changed.
  - left_aim/right_aim step the active angle by ±1, saturating at 0 and at max. Aim is unlimited.
  - Simultaneous inputs, which cannot occur from the decoder, are ignored (no change).
- PLAY, tick counter: increments on each tick. When it reaches TURN_TIMEOUT, the next state is SWITCH (turn forfeited, no fire).
- PLAY, fire edge: a rising edge of shoot_in (shoot_in & ~shoot_prev) moves to FIRE.
  - The fire edge beats both a tick action and a timeout in the same cycle.
  - shoot_prev updates every cycle in every state, so a shoot held across a turn change does not fire.
- FIRE: fire=1 for exactly this one cycle. Next state is FLIGHT. Latency from shoot edge to fire is 1 cycle.
- FLIGHT: movement and aim are frozen. On proj_done:
  - proj_hit=1: go to OVER, winner=active_player, game_over=1.
  - proj_hit=0: go to SWITCH.
  - proj_done seen outside FLIGHT is ignored.
- SWITCH: lasts one cycle. Toggles active_player, reloads moves_left=MOVE_BUDGET, clears the tick counter, then returns to PLAY.
- OVER: all positions and angles are held. The block leaves OVER only via start_new_game or reset.
- The inactive player's registers never change outside reset/new game.

Decomposition:
- Package turn_pkg holds:
  - the state enum, with fixed encodings IDLE=0, PLAY=1, FIRE=2, FLIGHT=3, SWITCH=4, OVER=5
  - the default constants for the parameters above
- One sub-module: sat_step.
  - Parameterised width/min/max register with enable, up, down and load inputs.
  - Outputs a "changed" flag.
  - Instantiated four times, once per p0_x, p1_x, p0_ang and p1_ang.

Test Plan:
- Reset, then start_new_game, then hold right_x for 3 ticks → p0_x 40→43, moves_left 29, p1_x still 215.
- In PLAY, player 0 holds left_aim for 10 ticks from 8 → p0_ang saturates at 0. Then pulse shoot → fire high exactly 1 cycle after the edge, state goes to FLIGHT.
- In FLIGHT, proj_done=1 with proj_hit=0 → SWITCH for one cycle, active_player=1, moves_left=32. A shoot held through this gives no fire.
- Spend 32 right_x ticks, then one more → x advances exactly 32, then holds, moves_left=0. Separately, set a position at POS_MAX and press right_x → no change and no budget consumed.
- Let the turn run TURN_TIMEOUT ticks with no input → SWITCH with fire never asserted. A shoot edge on the same cycle as the timeout tick → FIRE wins.
- proj_done with proj_hit=1 for player 1 → game_over=1, winner=1, inputs ignored. Then start_new_game → PLAY, player 0, positions 40/215, angles 8.
